// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and mode encoding for the parametrised FIFO family.
// Revision: 1.0
`default_nettype none

package fifo_pkg;

    typedef enum logic {
        MODE_STD  = 1'b0,
        MODE_FWFT = 1'b1
    } fifo_mode_e;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int count_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fwft_fifo_param_ram.sv
// fifo_sdp_ram: simple dual-port RAM, one write port, one synchronous read port.
// Revision: 1.0
`default_nettype none

module fifo_sdp_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    import fifo_pkg::*;

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Only the output register is reset; the array holds stale data after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/fwft_fifo_param.sv
// fwft_fifo_param: parametrised synchronous FIFO with optional first-word-fall-through output.
// Revision: 1.0
`default_nettype none

module fwft_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 1,
    parameter int AF_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  wr_overflow,
    output logic                  rd_underflow
);

    localparam int             CW      = count_width(ADDR_WIDTH);
    localparam int             DEPTH   = depth_of(ADDR_WIDTH);
    localparam fifo_mode_e     c_mode  = (FWFT != 0) ? MODE_FWFT : MODE_STD;
    localparam logic [CW-1:0]  c_depth = CW'(DEPTH);
    localparam logic [CW-1:0]  c_one   = CW'(1);
    localparam logic [CW-1:0]  c_af    = CW'(AF_THRESH);
    localparam logic [CW-1:0]  c_ae    = CW'(AE_THRESH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [CW-1:0]         r_ram_cnt;
    logic                  r_wr_overflow;
    logic                  r_rd_underflow;

    logic                  w_ram_full;
    logic                  w_ram_empty;
    logic                  w_wr_acc;
    logic                  w_int_rd;
    logic                  w_empty;
    logic [CW-1:0]         w_count;

    assign w_ram_full  = (r_ram_cnt == c_depth);
    assign w_ram_empty = (r_ram_cnt == '0);
    assign w_wr_acc    = wr_en && !w_ram_full;

    generate
        if (c_mode == MODE_FWFT) begin : g_fwft
            logic r_dav;

            // Prefetch whenever the output register is free or being popped.
            assign w_int_rd = !w_ram_empty && (!r_dav || rd_en);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_dav <= 1'b0;
                end else if (w_int_rd) begin
                    r_dav <= 1'b1;
                end else if (rd_en) begin
                    r_dav <= 1'b0;
                end
            end

            assign w_empty = !r_dav;
            assign w_count = r_ram_cnt + {{ADDR_WIDTH{1'b0}}, r_dav};
        end else begin : g_std
            assign w_int_rd = rd_en && !w_ram_empty;
            assign w_empty  = w_ram_empty;
            assign w_count  = r_ram_cnt;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_ram_cnt      <= '0;
            r_wr_overflow  <= 1'b0;
            r_rd_underflow <= 1'b0;
        end else begin
            r_wr_overflow  <= wr_en && w_ram_full;
            r_rd_underflow <= rd_en && w_empty;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_int_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_int_rd})
                2'b10:   r_ram_cnt <= r_ram_cnt + c_one;
                2'b01:   r_ram_cnt <= r_ram_cnt - c_one;
                default: r_ram_cnt <= r_ram_cnt;
            endcase
        end
    end

    fifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst_n     (reset_n),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (din),
        .i_rd_en   (w_int_rd),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (dout)
    );

    assign full         = w_ram_full;
    assign empty        = w_empty;
    assign count        = w_count;
    assign almost_full  = (w_count >= c_af);
    assign almost_empty = (w_count <= c_ae);
    assign wr_overflow  = r_wr_overflow;
    assign rd_underflow = r_rd_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fwft_fifo_param.sv
// tb_fwft_fifo_param: table and scoreboard checks of fwft_fifo_param in three configurations.
// Revision: 1.0
`default_nettype none

module tb_fwft_fifo_param;

    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] din = 8'h00;

    // u_dut0: AW=2 FWFT, u_dut1: AW=3 FWFT thresholds 6/1, u_dut2: AW=2 standard
    logic [7:0] dout0, dout1, dout2;
    logic       f0, f1, f2, e0, e1, e2, af0, af1, af2, ae0, ae1, ae2;
    logic [2:0] cnt0, cnt2;
    logic [3:0] cnt1;
    logic       ovf0, ovf1, ovf2, unf0, unf1, unf2;

    always #5 clk = ~clk;

    fwft_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout0), .full(f0), .empty(e0), .almost_full(af0), .almost_empty(ae0),
        .count(cnt0), .wr_overflow(ovf0), .rd_underflow(unf0));

    fwft_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout1), .full(f1), .empty(e1), .almost_full(af1), .almost_empty(ae1),
        .count(cnt1), .wr_overflow(ovf1), .rd_underflow(unf1));

    fwft_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout2), .full(f2), .empty(e2), .almost_full(af2), .almost_empty(ae2),
        .count(cnt2), .wr_overflow(ovf2), .rd_underflow(unf2));

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       acc;
        logic       e;
        logic       f;
        logic [2:0] cnt;
        logic       af;
        logic       ae;
        logic       chk_d;
        logic [7:0] dout;
    } vec_t;

    vec_t       tbl [10];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] sb_q [$];
    bit         sb_en = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drives one cycle; the word at the head of dout0 is compared when a pop is issued.
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic acc);
        wr_en = w;
        din   = d;
        rd_en = r;
        if (sb_en && r && sb_q.size() > 0) begin
            check("sb_dout", {24'h0, dout0}, {24'h0, sb_q.pop_front()});
        end
        if (sb_en && w && acc) begin
            sb_q.push_back(d);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        reset_n = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", {31'h0, e0}, 32'd1);
        check("rst_count", {29'h0, cnt0}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //        w  d      r  acc e  f  cnt af ae chk dout
        tbl[0] = '{1, 8'h11, 0, 1, 1, 0, 1, 0, 1, 0, 8'h00};
        tbl[1] = '{1, 8'h22, 0, 1, 0, 0, 2, 1, 0, 1, 8'h11};
        tbl[2] = '{1, 8'h33, 0, 1, 0, 0, 3, 1, 0, 1, 8'h11};
        tbl[3] = '{1, 8'h44, 0, 1, 0, 0, 4, 1, 0, 1, 8'h11};
        tbl[4] = '{1, 8'h55, 0, 1, 0, 1, 5, 1, 0, 1, 8'h11};
        tbl[5] = '{0, 8'h00, 1, 0, 0, 0, 4, 1, 0, 1, 8'h22};
        tbl[6] = '{0, 8'h00, 1, 0, 0, 0, 3, 1, 0, 1, 8'h33};
        tbl[7] = '{0, 8'h00, 1, 0, 0, 0, 2, 1, 0, 1, 8'h44};
        tbl[8] = '{0, 8'h00, 1, 0, 0, 0, 1, 0, 1, 1, 8'h55};
        tbl[9] = '{0, 8'h00, 1, 0, 1, 0, 0, 0, 1, 1, 8'h55};

        // Reset values and fill/drain
        do_reset();
        check("rst_dout", {24'h0, dout0}, 32'h0);
        check("rst_full", {31'h0, f0}, 32'd0);
        check("rst_ae", {31'h0, ae0}, 32'd1);
        check("rst_af", {31'h0, af0}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].acc);
            check($sformatf("tbl%0d_empty", i), {31'h0, e0}, {31'h0, tbl[i].e});
            check($sformatf("tbl%0d_full", i), {31'h0, f0}, {31'h0, tbl[i].f});
            check($sformatf("tbl%0d_count", i), {29'h0, cnt0}, {29'h0, tbl[i].cnt});
            check($sformatf("tbl%0d_af", i), {31'h0, af0}, {31'h0, tbl[i].af});
            check($sformatf("tbl%0d_ae", i), {31'h0, ae0}, {31'h0, tbl[i].ae});
            if (tbl[i].chk_d) begin
                check($sformatf("tbl%0d_dout", i), {24'h0, dout0}, {24'h0, tbl[i].dout});
            end
        end

        // Overflow and underflow
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b1);
        end
        check("ovf_full", {31'h0, f0}, 32'd1);
        check("ovf_idle", {31'h0, ovf0}, 32'd0);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        check("ovf_pulse", {31'h0, ovf0}, 32'd1);
        check("ovf_count", {29'h0, cnt0}, 32'd5);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("ovf_clear", {31'h0, ovf0}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("drain_empty", {31'h0, e0}, 32'd1);
        check("unf_idle", {31'h0, unf0}, 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("unf_pulse", {31'h0, unf0}, 32'd1);
        check("unf_count", {29'h0, cnt0}, 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("unf_clear", {31'h0, unf0}, 32'd0);

        // Simultaneous read/write at count 3 across pointer wrap
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b1);
        end
        check("rw_start_count", {29'h0, cnt0}, 32'd3);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'h13 + 8'(i), 1'b1, 1'b1);
            check($sformatf("rw%0d_count", i), {29'h0, cnt0}, 32'd3);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        check("rw_end_empty", {31'h0, e0}, 32'd1);
        check("rw_sb_left", sb_q.size(), 32'd0);

        // Standard mode on u_dut2
        sb_en = 1'b0;
        do_reset();
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        check("std_not_empty", {31'h0, e2}, 32'd0);
        check("std_dout_pre", {24'h0, dout2}, 32'h0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("std_dout", {24'h0, dout2}, 32'hA5);
        check("std_empty", {31'h0, e2}, 32'd1);
        check("std_count", {29'h0, cnt2}, 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("std_dout_hold", {24'h0, dout2}, 32'hA5);

        // Thresholds on u_dut1
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            step(1'b1, 8'(k), 1'b0, 1'b0);
            check($sformatf("thr_fill%0d_count", k), {28'h0, cnt1}, k);
            check($sformatf("thr_fill%0d_ae", k), {31'h0, ae1}, (k <= 1) ? 32'd1 : 32'd0);
            check($sformatf("thr_fill%0d_af", k), {31'h0, af1}, (k >= 6) ? 32'd1 : 32'd0);
        end
        for (int k = 6; k >= 0; k--) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            check($sformatf("thr_drain%0d_count", k), {28'h0, cnt1}, k);
            check($sformatf("thr_drain%0d_ae", k), {31'h0, ae1}, (k <= 1) ? 32'd1 : 32'd0);
            check($sformatf("thr_drain%0d_af", k), {31'h0, af1}, (k >= 6) ? 32'd1 : 32'd0);
        end
        sb_en = 1'b1;

        // Asynchronous reset mid-burst
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1);
        end
        check("arst_pre_count", {29'h0, cnt0}, 32'd4);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_empty", {31'h0, e0}, 32'd1);
        check("arst_count", {29'h0, cnt0}, 32'd0);
        check("arst_dout", {24'h0, dout0}, 32'h0);
        sb_q.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'h3C, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("arst_latency_empty", {31'h0, e0}, 32'd0);
        check("arst_first_dout", {24'h0, dout0}, 32'h3C);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("arst_final_empty", {31'h0, e0}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
